// File: rtl/dcma_ctrl_pkg.sv
// Shared constants for the dynamic clock mux select controller:
// state encodings, source encodings and width helpers.
package dcma_ctrl_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_GATE   = 3'd1;
  localparam logic [2:0] ST_SWITCH = 3'd2;
  localparam logic [2:0] ST_ENABLE = 3'd3;
  localparam logic [2:0] ST_DWELL  = 3'd4;

  localparam logic SRC_CLK0 = 1'b0;
  localparam logic SRC_CLK1 = 1'b1;

  // Wide enough to hold max(settle, hold); never narrower than one bit.
  function automatic int cnt_width(input int settle, input int hold);
    int m;
    m = (settle > hold) ? settle : hold;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dcma_rr_arb.sv
// Combinational round-robin arbiter: the search starts at i_ptr and wraps.
// The pointer register is owned by the parent.
module dcma_rr_arb
  import dcma_ctrl_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int PW   = ptr_width(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic            o_valid
);

  // First pass covers ptr..NREQ-1, second pass picks up the wrapped low indices.
  always_comb begin
    o_gnt   = '0;
    o_valid = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!o_valid && i_req[i] && (i >= int'(i_ptr))) begin
        o_gnt[i] = 1'b1;
        o_valid  = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!o_valid && i_req[i]) begin
        o_gnt[i] = 1'b1;
        o_valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dcma_sel_ctrl.sv
// Request arbiter and glitch-safe select sequencer for the dynamic clock mux:
// gate CEN, settle, flip SEL, settle, re-enable, then dwell.
module dcma_sel_ctrl
  import dcma_ctrl_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int SETTLE_CYC = 4,
  parameter int HOLD_CYC   = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NREQ-1:0] REQ,
  input  logic [NREQ-1:0] REQSRC,
  output logic [NREQ-1:0] GNT,
  output logic            SEL,
  output logic            CEN,
  output logic            BUSY,
  output logic            CURSRC
);

  localparam int CW = cnt_width(SETTLE_CYC, HOLD_CYC);
  localparam int PW = ptr_width(NREQ);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LOAD   = CW'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
  localparam logic [PW-1:0] LAST_IDX    = PW'(NREQ - 1);

  logic [2:0]      r_state;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_nptr;
  logic [NREQ-1:0] r_win;
  logic [NREQ-1:0] r_gnt;
  logic            r_tgt;
  logic            r_sel;
  logic            r_cen;
  logic            r_busy;
  logic            r_cursrc;

  logic [NREQ-1:0] w_arb_gnt;
  logic            w_arb_valid;
  logic [PW-1:0]   w_win_idx;
  logic [PW-1:0]   w_nptr;
  logic            w_win_src;
  logic            w_cnt_done;

  dcma_rr_arb #(.NREQ(NREQ), .PW(PW)) u_arb (
    .i_req   (REQ),
    .i_ptr   (r_ptr),
    .o_gnt   (w_arb_gnt),
    .o_valid (w_arb_valid)
  );

  // NOTE: every variable gets a default before the loop, so no latch is inferred.
  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_arb_gnt[i]) w_win_idx = PW'(i);
    end
    w_nptr = (w_win_idx == LAST_IDX) ? '0 : w_win_idx + 1'b1;
  end

  assign w_win_src  = |(REQSRC & w_arb_gnt);
  assign w_cnt_done = (r_cnt == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_ptr    <= '0;
      r_nptr   <= '0;
      r_win    <= '0;
      r_gnt    <= '0;
      r_tgt    <= SRC_CLK0;
      r_sel    <= SRC_CLK0;
      r_cen    <= 1'b1;
      r_busy   <= 1'b0;
      r_cursrc <= SRC_CLK0;
    end else begin
      r_gnt <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_arb_valid) begin
            r_win  <= w_arb_gnt;
            r_nptr <= w_nptr;
            if (w_win_src == r_cursrc) begin
              r_gnt <= w_arb_gnt;
              r_ptr <= w_nptr;
            end else begin
              r_tgt   <= w_win_src;
              r_state <= ST_GATE;
              r_cnt   <= SETTLE_LOAD;
              r_cen   <= 1'b0;
              r_busy  <= 1'b1;
            end
          end
        end
        ST_GATE: begin
          if (w_cnt_done) begin
            r_state <= ST_SWITCH;
            r_cnt   <= SETTLE_LOAD;
            r_sel   <= r_tgt;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_SWITCH: begin
          if (w_cnt_done) begin
            r_state  <= ST_ENABLE;
            r_cen    <= 1'b1;
            r_cursrc <= r_sel;
            r_gnt    <= r_win;
            r_ptr    <= r_nptr;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_ENABLE: begin
          if (HOLD_CYC == 0) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= ST_DWELL;
            r_cnt   <= HOLD_LOAD;
          end
        end
        ST_DWELL: begin
          if (w_cnt_done) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cen   <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign GNT    = r_gnt;
  assign SEL    = r_sel;
  assign CEN    = r_cen;
  assign BUSY   = r_busy;
  assign CURSRC = r_cursrc;

endmodule
